// File: rtl/ads1672_pkg.sv
// Shared constants, FSM state type and sign-extension helper for the ADS1672 capture path.
package ads1672_pkg;

    localparam int DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } capture_state_t;

    // Returns bit idx of a two's-complement value whose sign bit sits at msb,
    // replicating the sign for every position above msb.
    function automatic logic sign_extend_bit(input logic [63:0] value, input int msb, input int idx);
        logic [5:0] sel;
        sel = (idx > msb) ? msb[5:0] : idx[5:0];
        return value[sel];
    endfunction

endpackage

// File: rtl/ads1672_sample_capture_if.sv
// Sample input strobe plus valid/ready output stream of the capture block.
interface ads1672_sample_capture_if #(
    parameter int DATA_WIDTH = ads1672_pkg::DATA_WIDTH,
    parameter int OUT_WIDTH  = 32
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [OUT_WIDTH-1:0]  m_data;

    modport master (output s_valid, s_data, m_ready, input m_valid, m_data);
    modport slave  (input s_valid, s_data, m_ready, output m_valid, m_data);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with wrapping pointers and a separate occupancy counter.
module sync_fifo_fwft #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign w_doPop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_data;
    end

    assign o_data  = o_empty ? '0 : r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/ads1672_sample_capture.sv
// Captures a window of ADC samples on measure, sign-extends them and streams them out via a FWFT FIFO.
module ads1672_sample_capture #(
    parameter int DATA_WIDTH  = ads1672_pkg::DATA_WIDTH,
    parameter int OUT_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int CAPTURE_LEN = 1024,
    parameter int CNT_WIDTH   = $clog2(CAPTURE_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        measure,
    input  logic                        abort,
    ads1672_sample_capture_if.slave     bus,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [CNT_WIDTH-1:0]        sample_count
);
    import ads1672_pkg::*;

    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    capture_state_t          r_state;
    capture_state_t          w_nextState;
    logic [CNT_WIDTH-1:0]    r_sampleCount;
    logic                    r_overflow;
    logic [OUT_WIDTH-1:0]    w_extData;
    logic [OUT_WIDTH-1:0]    w_fifoData;
    logic [FIFO_CNT_W-1:0]   w_fifoCount;
    logic                    w_fifoFull;
    logic                    w_fifoEmpty;
    logic                    w_start;
    logic                    w_capSample;
    logic                    w_lastSample;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;

    // Abort outranks everything, so it masks both window start and sample capture.
    assign w_pop        = !w_fifoEmpty && bus.m_ready;
    assign w_start      = (r_state == IDLE) && measure && !abort;
    assign w_capSample  = (r_state == CAPTURE) && bus.s_valid && !abort;
    assign w_push       = w_capSample && (!w_fifoFull || w_pop);
    assign w_flush      = abort || w_start;
    assign w_lastSample = w_capSample && ((r_sampleCount + 1'b1) == CNT_WIDTH'(CAPTURE_LEN));

    always_comb begin
        w_extData = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_extData[i] = sign_extend_bit(64'(bus.s_data), DATA_WIDTH - 1, i);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_extData),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_fifoData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    always_comb begin
        assert (w_fifoCount <= FIFO_CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (measure)      w_nextState = CAPTURE;
                CAPTURE: if (w_lastSample) w_nextState = DRAIN;
                DRAIN:   if (w_fifoEmpty)  w_nextState = IDLE;
                default:                   w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DRAIN) && w_fifoEmpty && !abort;
    end

    // Dropped samples still count toward the window length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sampleCount <= '0;
            r_overflow    <= 1'b0;
        end else if (w_start) begin
            r_sampleCount <= '0;
            r_overflow    <= 1'b0;
        end else if (w_capSample) begin
            r_sampleCount <= r_sampleCount + 1'b1;
            if (!w_push) r_overflow <= 1'b1;
        end
    end

    assign bus.m_valid  = !w_fifoEmpty;
    assign bus.m_data   = w_fifoData;
    assign overflow     = r_overflow;
    assign sample_count = r_sampleCount;

endmodule

// File: tb/tb_ads1672_sample_capture.sv
// Directed bench: instance A (window 4, depth 4) and instance B (window 6, depth 4) with hand-computed expectations.
module tb_ads1672_sample_capture;
    import ads1672_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       measA, abortA, busyA, doneA, ovfA;
    logic       measB, abortB, busyB, doneB, ovfB;
    logic [2:0] cntA, cntB;

    int checkCount = 0;
    int passCount  = 0;

    logic [23:0] basicIn  [4] = '{24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF};
    logic [31:0] basicOut [4] = '{32'h00000001, 32'h007FFFFF, 32'hFF800000, 32'hFFFFFFFF};

    ads1672_sample_capture_if #(.DATA_WIDTH(24), .OUT_WIDTH(32)) busA ();
    ads1672_sample_capture_if #(.DATA_WIDTH(24), .OUT_WIDTH(32)) busB ();

    ads1672_sample_capture #(
        .DATA_WIDTH(24), .OUT_WIDTH(32), .FIFO_DEPTH(4), .CAPTURE_LEN(4)
    ) u_dutA (
        .clk(clk), .rst_n(rst_n), .measure(measA), .abort(abortA), .bus(busA),
        .busy(busyA), .done(doneA), .overflow(ovfA), .sample_count(cntA)
    );

    ads1672_sample_capture #(
        .DATA_WIDTH(24), .OUT_WIDTH(32), .FIFO_DEPTH(4), .CAPTURE_LEN(6)
    ) u_dutB (
        .clk(clk), .rst_n(rst_n), .measure(measB), .abort(abortB), .bus(busB),
        .busy(busyB), .done(doneB), .overflow(ovfB), .sample_count(cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Holds one cycle of inputs on the selected instance, then returns 1 time unit after the edge.
    task automatic applyStimulus(input bit useB, input logic meas, input logic abt,
                                 input logic sv, input logic [23:0] sd);
        if (useB) begin
            measB = meas; abortB = abt; busB.s_valid = sv; busB.s_data = sd;
        end else begin
            measA = meas; abortA = abt; busA.s_valid = sv; busA.s_data = sd;
        end
        @(posedge clk);
        #1;
        measA = 1'b0; abortA = 1'b0; busA.s_valid = 1'b0;
        measB = 1'b0; abortB = 1'b0; busB.s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        measA = 1'b0; abortA = 1'b0; busA.s_valid = 1'b0; busA.s_data = '0; busA.m_ready = 1'b0;
        measB = 1'b0; abortB = 1'b0; busB.s_valid = 1'b0; busB.s_data = '0; busB.m_ready = 1'b0;
        #2;
        checkOutput("rst m_valid", 64'(busA.m_valid), 64'd0);
        checkOutput("rst m_data", 64'(busA.m_data), 64'd0);
        checkOutput("rst busy", 64'(busyA), 64'd0);
        checkOutput("rst done", 64'(doneA), 64'd0);
        checkOutput("rst overflow", 64'(ovfA), 64'd0);
        checkOutput("rst count", 64'(cntA), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic capture, sign extension and done pulse
        busA.m_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        checkOutput("start busy", 64'(busyA), 64'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, basicIn[k]);
            checkOutput("basic m_valid", 64'(busA.m_valid), 64'd1);
            checkOutput("basic m_data", 64'(busA.m_data), 64'(basicOut[k]));
            checkOutput("basic count", 64'(cntA), 64'(k + 1));
        end
        checkOutput("basic state drain", 64'(u_dutA.r_state), 64'(DRAIN));
        checkOutput("basic done early", 64'(doneA), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("basic done", 64'(doneA), 64'd1);
        checkOutput("basic drained", 64'(busA.m_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("basic done once", 64'(doneA), 64'd0);
        checkOutput("basic busy fall", 64'(busyA), 64'd0);
        checkOutput("basic overflow", 64'(ovfA), 64'd0);
        checkOutput("basic count held", 64'(cntA), 64'd4);

        // Ignored inputs in IDLE and CAPTURE
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h123456);
        checkOutput("idle sv m_valid", 64'(busA.m_valid), 64'd0);
        checkOutput("idle sv count", 64'(cntA), 64'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 24'h000055);
        checkOutput("measure+sv busy", 64'(busyA), 64'd1);
        checkOutput("measure+sv count", 64'(cntA), 64'd0);
        checkOutput("measure+sv m_valid", 64'(busA.m_valid), 64'd0);
        busA.m_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h000010);
        checkOutput("cap s1 count", 64'(cntA), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        checkOutput("cap measure count", 64'(cntA), 64'd1);
        checkOutput("cap hold data", 64'(busA.m_data), 64'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFF0);
        checkOutput("cap s2 count", 64'(cntA), 64'd2);
        checkOutput("cap head stable", 64'(busA.m_data), 64'h10);

        // Abort after two samples
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        checkOutput("abort m_valid", 64'(busA.m_valid), 64'd0);
        checkOutput("abort busy", 64'(busyA), 64'd0);
        checkOutput("abort done", 64'(doneA), 64'd0);
        checkOutput("abort count", 64'(cntA), 64'd2);
        checkOutput("abort m_data", 64'(busA.m_data), 64'd0);

        // Asynchronous reset during CAPTURE, then a clean capture
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'hFFFFFE);
        checkOutput("pre-rst m_data", 64'(busA.m_data), 64'hFFFFFFFE);
        checkOutput("pre-rst busy", 64'(busyA), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async m_valid", 64'(busA.m_valid), 64'd0);
        checkOutput("async m_data", 64'(busA.m_data), 64'd0);
        checkOutput("async busy", 64'(busyA), 64'd0);
        checkOutput("async count", 64'(cntA), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        busA.m_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        checkOutput("post-rst busy", 64'(busyA), 64'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h000100 + 24'(k));
            checkOutput("post-rst m_data", 64'(busA.m_data), 64'(32'h00000100 + 32'(k)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("post-rst done", 64'(doneA), 64'd1);

        // Overflow: six samples into a four-deep FIFO with the consumer stalled
        busB.m_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h100000 * 24'(k + 1));
        end
        checkOutput("ovf occupancy", 64'(u_dutB.u_fifo.r_count), 64'd4);
        checkOutput("ovf not yet", 64'(ovfB), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h500000);
        checkOutput("ovf set", 64'(ovfB), 64'd1);
        checkOutput("ovf count5", 64'(cntB), 64'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h600000);
        checkOutput("ovf count6", 64'(cntB), 64'd6);
        checkOutput("ovf state", 64'(u_dutB.r_state), 64'(DRAIN));
        checkOutput("ovf stored", 64'(u_dutB.u_fifo.r_count), 64'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("ovf stall done", 64'(doneB), 64'd0);
        checkOutput("ovf stall busy", 64'(busyB), 64'd1);
        busB.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("ovf drain data", 64'(busB.m_data), 64'(32'h00100000 * 32'(k + 1)));
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        end
        checkOutput("ovf drain empty", 64'(busB.m_valid), 64'd0);
        checkOutput("ovf done", 64'(doneB), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("ovf idle busy", 64'(busyB), 64'd0);
        checkOutput("ovf sticky", 64'(ovfB), 64'd1);
        checkOutput("ovf count held", 64'(cntB), 64'd6);

        // Full FIFO with a pop and push in the same cycle
        busB.m_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        checkOutput("fp ovf cleared", 64'(ovfB), 64'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h000011 + 24'(k));
        end
        checkOutput("fp full", 64'(u_dutB.u_fifo.r_count), 64'd4);
        busB.m_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h000015);
        checkOutput("fp occupancy", 64'(u_dutB.u_fifo.r_count), 64'd4);
        checkOutput("fp overflow", 64'(ovfB), 64'd0);
        checkOutput("fp count", 64'(cntB), 64'd5);
        checkOutput("fp head", 64'(busB.m_data), 64'h12);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h000016);
        checkOutput("fp last state", 64'(u_dutB.r_state), 64'(DRAIN));
        for (int k = 0; k < 4; k++) begin
            checkOutput("fp drain data", 64'(busB.m_data), 64'(32'h00000013 + 32'(k)));
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        end
        checkOutput("fp done", 64'(doneB), 64'd1);
        checkOutput("fp final overflow", 64'(ovfB), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ads1672_sample_capture.md
Name: ads1672_sample_capture

Overview:
- Downstream consumer of the ADS1672-EVM serial interface block; it takes each deserialised 24-bit conversion result.
- On a `measure` pulse it arms a capture window of `CAPTURE_LEN` samples.
- Captured samples are sign-extended to `OUT_WIDTH` and buffered in a first-word-fall-through FIFO.
- Samples leave on a valid/ready stream toward the host/DMA side, with done and overflow status.

Parameters:
- DATA_WIDTH, 24, width of ADC sample (two's complement).
- OUT_WIDTH, 32, width of output word; must be >= DATA_WIDTH.
- FIFO_DEPTH, 16, buffer entries; power of two, >= 2.
- CAPTURE_LEN, 1024, samples per capture window; >= 1.
- CNT_WIDTH, $clog2(CAPTURE_LEN+1), width of the sample counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- measure  in  1  single-cycle pulse: start capture window.
- abort  in  1  single-cycle pulse: cancel capture, flush FIFO.
- s_valid  in  1  strobe, one cycle per new sample from ADC interface.
- s_data  in  DATA_WIDTH  sample, valid when s_valid=1.
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts word.
- m_data  out  OUT_WIDTH  sign-extended sample.
- busy  out  1  high in CAPTURE or DRAIN.
- done  out  1  one-cycle pulse when window complete and FIFO drained.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- sample_count  out  CNT_WIDTH  samples seen in the current window, accepted plus dropped.

Behaviour:
- Reset (async assert, sync deassert via `clk`) sets all outputs to the following values:
  - m_valid=0, m_data=0, busy=0, done=0, overflow=0, sample_count=0.
  - State is IDLE and the FIFO is empty.
- The FSM has three states: IDLE, CAPTURE, DRAIN.
  - IDLE: `measure` goes to CAPTURE next cycle; it clears sample_count and overflow and empties the FIFO. `s_valid` is ignored in IDLE, including in the same cycle as `measure`.
  - CAPTURE: each `s_valid` increments sample_count.
    - The sample is written to the FIFO if occupancy < FIFO_DEPTH, or if a pop happens in the same cycle (m_valid&&m_ready). A simultaneous push and pop when full leaves occupancy unchanged.
    - Otherwise the sample is dropped and overflow is set.
    - When sample_count reaches CAPTURE_LEN (counting the current sample), the FSM goes to DRAIN next cycle.
  - DRAIN: `s_valid` is ignored. When the FIFO is empty, `done` pulses for one cycle and the FSM returns to IDLE.
    - If the FIFO is already empty on entry, `done` pulses in the first DRAIN cycle.
- `measure` in CAPTURE or DRAIN is ignored.
- `abort` in any state gives the following on the next cycle:
  - state is IDLE and the FIFO is flushed (m_valid=0).
  - `done` is not pulsed.
  - overflow and sample_count are held.
- `abort` and `measure` in the same cycle: `abort` wins.
- Output path:
  - m_data = {{(OUT_WIDTH-DATA_WIDTH){s[DATA_WIDTH-1]}}, s}.
  - FWFT: a sample pushed at cycle N has m_valid=1 and m_data valid at cycle N+1.
  - m_data holds stable while m_valid && !m_ready.
  - m_valid deasserts the cycle after the last word pops.
- The FIFO uses wrapping pointers of width $clog2(FIFO_DEPTH) and a separate occupancy counter of width $clog2(FIFO_DEPTH)+1. Full and empty are decoded from occupancy.
- busy = (state != IDLE).

Decomposition:
- Shared package `ads1672_pkg`:
  - DATA_WIDTH constant.
  - `capture_state_t` enum {IDLE, CAPTURE, DRAIN}.
  - sign-extension function.
- One sub-module: `sync_fifo_fwft`, parameterised by width and depth, with push/pop/flush, full/empty and occupancy. The top level holds the FSM, counter and status logic.

Test Plan:
- Basic capture:
  - Setup: CAPTURE_LEN=4, m_ready=1; pulse measure, then s_valid with 0x000001, 0x7FFFFF, 0x800000, 0xFFFFFF.
  - Required response: m_data = 0x00000001, 0x007FFFFF, 0xFF800000, 0xFFFFFFFF, each one cycle after its push; done pulses once; busy falls; overflow=0.
- Overflow:
  - Setup: FIFO_DEPTH=4, CAPTURE_LEN=6, m_ready=0; send 6 samples.
  - Required response: 4 stored, overflow=1, sample_count=6, state DRAIN. Raising m_ready gives 4 words then done.
- Full with simultaneous pop:
  - Stimulus: FIFO full, m_ready=1 and s_valid in the same cycle.
  - Required response: sample accepted, occupancy stays 4, overflow stays 0.
- Ignored inputs:
  - IDLE: s_valid without measure writes nothing (m_valid stays 0).
  - CAPTURE: measure mid-window leaves sample_count unaffected.
- Abort:
  - Stimulus: abort after 2 of 4 samples with m_ready=0.
  - Required response: next cycle m_valid=0, busy=0, no done pulse, sample_count=2.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during CAPTURE.
  - Required response: outputs reach reset values immediately without a clock edge; after release, a new measure captures normally.
